fifo_write_arbiter: RTL

Round-robin arbiter that shares the single write port of the parallel-width FIFO among NUM_REQ producers. Each producer presents PAR_WRITE words per beat over a valid/ready handshake. The arbiter grants one owner at a time for a burst of up to BURST beats and forwards the owner's beats to the FIFO whenever the FIFO can accept a write. It also sequences a FIFO clear on request, and sits directly in front of the FIFO's wen/din/clear inputs.

---
 rtl/fifo_write_arbiter.sv | 79 +++++++
 1 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter onto one FIFO write port; in clk,rst,req_valid,req_data,flush,fifo_ready; out req_ready,fifo_wen,fifo_din,fifo_clear,grant,grant_id
module fifo_write_arbiter #(
  parameter int SIZE = 4,
  parameter int PAR_WRITE = 2,
  parameter int NUM_REQ = 4,
  parameter int BURST = 4,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int W = PAR_WRITE * SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 flush,
  input  logic                 fifo_ready,
  output logic                 fifo_wen,
  output logic [W-1:0]         fifo_din,
  output logic                 fifo_clear,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IW-1:0]        grant_id
);
  localparam int CW = BURST > 1 ? $clog2(BURST) : 1;
  localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, FLUSH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, start, pick;
  logic [CW-1:0] cnt_q, cnt_d;
  logic in_grant, xfer, rel, any;
  always_comb begin
    in_grant = state_q == GRANT;
    xfer = in_grant && req_valid[owner_q] && fifo_ready;
    rel = !req_valid[owner_q] || (xfer && cnt_q == CW'(BURST - 1));
    any = |req_valid;
    start = in_grant ? owner_q : last_q;
    pick = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      pick = req_valid[(int'(start) + k) % NUM_REQ] ? IW'((int'(start) + k) % NUM_REQ) : pick;
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    cnt_d = cnt_q;
    if (flush) begin
      state_d = FLUSH;
      owner_d = '0;
      last_d = IW'(NUM_REQ - 1);
      cnt_d = '0;
    end else if (state_q == FLUSH) begin
      state_d = IDLE;
    end else if (in_grant) begin
      last_d = rel ? owner_q : last_q;
      state_d = rel ? (any ? GRANT : IDLE) : GRANT;
      owner_d = rel ? (any ? pick : '0) : owner_q;
      cnt_d = rel ? '0 : cnt_q + CW'(xfer);
    end else begin
      state_d = any ? GRANT : IDLE;
      owner_d = any ? pick : '0;
      cnt_d = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
    end
  end
  assign fifo_wen = xfer;
  assign fifo_din = in_grant ? req_data[int'(owner_q)*W +: W] : '0;
  assign req_ready = (in_grant && fifo_ready) ? NUM_REQ'(1) << owner_q : '0;
  assign grant = in_grant ? NUM_REQ'(1) << owner_q : '0;
  assign grant_id = in_grant ? owner_q : '0;
  assign fifo_clear = state_q == FLUSH;
endmodule
